// File: rtl/mcu_mailbox_ctrl.sv
// Mailbox handshake controller between the UART byte FIFOs and the MCU
// port-expander nibble registers. Read mode moves one RX byte into a
// holding register and presents it on ports 0/1. Write mode pushes one
// MCU byte to the TX FIFO. Both directions use a two-phase handshake on
// port 3, with a mode-change abort and a timeout abort.
module mcu_mailbox_ctrl #(
  parameter int TIMEOUT_CYC = 800000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] p3_ctl,
  input  logic [3:0] p0_wr,
  input  logic [3:0] p1_wr,
  output logic [3:0] p0_rd,
  output logic [3:0] p1_rd,
  output logic [3:0] p2_rd,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_PRESENT,
    RD_RELEASE,
    WR_PUSH,
    WR_RELEASE
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       p3_q, p0_q, p1_q;
  logic [7:0]       hold, hold_nxt;
  logic             hold_valid, hold_valid_nxt;
  logic             dav_n, dav_n_nxt;
  logic             wack_n, wack_n_nxt;
  logic             terr, terr_nxt;
  logic             tx_valid_nxt;
  logic [7:0]       tx_data_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pop, to_hit, to_set, abort;

  // Control port sample; idle-high values so nothing starts out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p3_q <= 4'hF;
    end else begin
      p3_q <= p3_ctl;
    end
  end

  // Data nibble sample and holding register (data only, no reset needed).
  always_ff @(posedge clk) begin
    p0_q <= p0_wr;
    p1_q <= p1_wr;
    hold <= hold_nxt;
  end

  // Next-state and registered-output decode; events beat aborts, and on
  // the read side a mode change beats read_complete_n.
  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold;
    hold_valid_nxt = hold_valid;
    dav_n_nxt      = dav_n;
    wack_n_nxt     = wack_n;
    tx_valid_nxt   = tx_valid;
    tx_data_nxt    = tx_data;
    pop            = 1'b0;
    to_set         = 1'b0;
    abort          = 1'b0;
    to_hit         = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    case (state)
      IDLE: begin
        if (!p3_q[0]) begin
          if (hold_valid) begin
            dav_n_nxt = 1'b0;
            state_nxt = RD_PRESENT;
          end else if (rx_valid) begin
            pop            = 1'b1;
            hold_nxt       = rx_data;
            hold_valid_nxt = 1'b1;
            dav_n_nxt      = 1'b0;
            state_nxt      = RD_PRESENT;
          end
        end else if (!p3_q[2]) begin
          tx_data_nxt  = {p1_q, p0_q};
          tx_valid_nxt = 1'b1;
          state_nxt    = WR_PUSH;
        end
      end
      RD_PRESENT: begin
        if (p3_q[0]) begin
          abort = 1'b1;
        end else if (!p3_q[1]) begin
          hold_valid_nxt = 1'b0;
          dav_n_nxt      = 1'b1;
          state_nxt      = RD_RELEASE;
        end else if (to_hit) begin
          to_set = 1'b1;
        end
      end
      RD_RELEASE: begin
        if (p3_q[0]) begin
          abort = 1'b1;
        end else if (p3_q[1]) begin
          state_nxt = IDLE;
        end else if (to_hit) begin
          to_set = 1'b1;
        end
      end
      WR_PUSH: begin
        // tx_valid is always high here, so tx_ready alone is the handshake.
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          wack_n_nxt   = 1'b0;
          state_nxt    = WR_RELEASE;
        end else if (!p3_q[0]) begin
          abort = 1'b1;
        end else if (to_hit) begin
          to_set = 1'b1;
        end
      end
      WR_RELEASE: begin
        if (!p3_q[0]) begin
          abort = 1'b1;
        end else if (p3_q[2]) begin
          wack_n_nxt = 1'b1;
          state_nxt  = IDLE;
        end else if (to_hit) begin
          to_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort || to_set) begin
      state_nxt    = IDLE;
      dav_n_nxt    = 1'b1;
      wack_n_nxt   = 1'b1;
      tx_valid_nxt = 1'b0;
    end
    if (state_nxt != state || state == IDLE) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
    if (to_set) begin
      terr_nxt = 1'b1;
    end else if (!p3_q[3]) begin
      terr_nxt = 1'b0;
    end else begin
      terr_nxt = terr;
    end
  end

  // State, handshake flags, timeout counter and MCU-visible read nibbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      dav_n      <= 1'b1;
      wack_n     <= 1'b1;
      terr       <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      cnt        <= '0;
      p0_rd      <= 4'h0;
      p1_rd      <= 4'h0;
    end else begin
      state      <= state_nxt;
      hold_valid <= hold_valid_nxt;
      dav_n      <= dav_n_nxt;
      wack_n     <= wack_n_nxt;
      terr       <= terr_nxt;
      tx_valid   <= tx_valid_nxt;
      tx_data    <= tx_data_nxt;
      cnt        <= cnt_nxt;
      // Track the next hold value so the nibbles are valid in the same
      // cycle data_avail_n first reads low.
      if (hold_valid_nxt) begin
        p0_rd <= hold_nxt[3:0];
        p1_rd <= hold_nxt[7:4];
      end
    end
  end

  assign rx_ready = pop;
  assign p2_rd    = {wack_n, terr, p3_q[0], dav_n};
  assign busy     = (state != IDLE);

endmodule

// File: doc/mcu_mailbox_ctrl.md
Name: mcu_mailbox_ctrl

Overview:
- Sequences byte transfers between the UART byte streams and the OKI MCU over the 4-bit port-expander registers (ports 0/1 data nibbles, port 2 status, port 3 control).
- The expander decode (READ/WRITE/OR/AND on prog_n) lives elsewhere. This block only owns the mailbox handshake state machine and the status nibble the MCU polls.
- It sits in top between the expander register file and the UART RX/TX FIFOs.

Parameters:
- TIMEOUT_CYC, 800000, clk cycles allowed in any MCU wait state before abort (100 ms at 8 MHz).
- CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, 8 MHz.
- rst_n  in  1  asynchronous active-low reset.
- p3_ctl  in  4  MCU-written control port value.
  - [0] mode: 0 = read (FPGA->MCU), 1 = write.
  - [1] read_complete_n.
  - [2] write_avail_n.
  - [3] err_clr_n.
- p0_wr  in  4  MCU-written low data nibble.
- p1_wr  in  4  MCU-written high data nibble.
- p0_rd  out  4  low nibble presented to MCU reads.
- p1_rd  out  4  high nibble presented to MCU reads.
- p2_rd  out  4  status nibble.
  - [0] data_avail_n.
  - [1] mode echo.
  - [2] timeout_err.
  - [3] wr_ack_n.
- rx_data  in  8  byte from UART RX FIFO.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  pop strobe to RX FIFO.
- tx_data  out  8  byte to UART TX FIFO.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  TX FIFO can accept.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - p0_rd = 0, p1_rd = 0, p2_rd = 4'b1011.
  - rx_ready = 0, tx_valid = 0, tx_data = 0, busy = 0.
  - hold_valid = 0, timeout_err = 0, state = IDLE.
- All p3_ctl/p0_wr/p1_wr inputs are synchronous to clk and sampled registered.
- p2_rd[1] = p3_ctl[0] registered (1-cycle delay). p2_rd[2] = timeout_err.
- Holding register hold[7:0] plus flag hold_valid.
- p0_rd/p1_rd = hold[3:0]/hold[7:4] whenever hold_valid. They are otherwise held at their last value.
- States:
  - IDLE:
    - mode=0 and hold_valid -> RD_PRESENT.
    - mode=0, !hold_valid, rx_valid -> capture rx_data into hold, pulse rx_ready for exactly 1 cycle, set hold_valid, -> RD_PRESENT.
    - mode=1 and p3_ctl[2]=0 -> capture {p1_wr,p0_wr} into tx_data, assert tx_valid, -> WR_PUSH.
  - RD_PRESENT:
    - drive p2_rd[0]=0 (first cycle = capture cycle + 1).
    - On p3_ctl[1]=0: clear hold_valid, p2_rd[0]=1, -> RD_RELEASE.
  - RD_RELEASE:
    - wait p3_ctl[1]=1 -> IDLE.
    - A new byte is never presented while read_complete_n is still 0.
  - WR_PUSH:
    - tx_valid held with tx_data stable until tx_valid&&tx_ready.
    - On that cycle drop tx_valid, set p2_rd[3]=0, -> WR_RELEASE.
  - WR_RELEASE:
    - wait p3_ctl[2]=1 -> set p2_rd[3]=1, -> IDLE.
    - Exactly one tx byte per write_avail_n falling handshake.
- Mode change (p3_ctl[0] differs from the mode the current state belongs to) in any non-IDLE state:
  - Next cycle -> IDLE; p2_rd[0]=1, p2_rd[3]=1, tx_valid=0.
  - Read-side byte stays in hold (hold_valid unchanged unless already cleared) and is re-presented on return to read mode; no byte lost or duplicated.
  - Write side aborted before the tx handshake pushes nothing.
- Timeout:
  - Counter clears on every state entry and increments in RD_PRESENT, RD_RELEASE, WR_PUSH and WR_RELEASE.
  - On reaching TIMEOUT_CYC: set timeout_err (sticky), apply the same abort action as a mode change, -> IDLE.
  - timeout_err clears on any cycle with p3_ctl[3]=0. If a clear and a new timeout occur in the same cycle, set wins.
- Simultaneous events: in IDLE with mode=0, hold_valid takes priority over rx_valid (no pop).
- Reset mid-transfer returns everything to reset values. A held byte is discarded; it was already popped.
- busy = (state != IDLE).

Test Plan:
- Reset, p3_ctl=4'b1111 -> p2_rd=4'b1011, rx_ready=0, tx_valid=0, busy=0.
- Read stream: mode=0, RX supplies DE,AD,BE,EF, MCU does full handshake per byte (wait p2_rd[0]=0, read p0/p1, p3[1]=0, wait p2_rd[0]=1, p3[1]=1) -> MCU sees E/D, D/A, E/B, F/E in order, exactly 4 rx_ready pulses, data_avail_n=0 exactly one cycle after each pop.
- Write: mode=1, p0_wr=4, p1_wr=4, p3[2]=0, tx_ready low 20 cycles then high -> tx_data=8'h44 stable with tx_valid for 20 cycles, one accept, p2_rd[3]=0 until p3[2]=1, then 1 next cycle.
- Mode switch: byte 8'hAD presented, mode->1 before read_complete -> p2_rd[0]=1, no extra pop. Back to mode=0 -> AD re-presented and consumed once.
- Timeout (TIMEOUT_CYC=100): present byte, MCU never asserts read_complete -> at cycle 100 p2_rd[2]=1, state IDLE, byte retained. p3[3]=0 one cycle -> p2_rd[2]=0.
- Hold-low: MCU leaves p3[1]=0 after a transfer while rx_valid is high -> no new pop or presentation until p3[1]=1.
